// File: rtl/jtframe_linemult.sv
// jtframe_linemult: ping-pong line buffer that replays each input line
// FACTOR times at FACTOR times the pixel rate, with optional horizontal
// blending, last-sub-line dimming and regenerated syncs.

// Per-channel blend and dim stage. One instance per colour channel, so no
// carry can cross from one channel into the next.
module jtframe_linemult_ch #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] cur,
    input  logic [CW-1:0] prev,
    input  logic          blend_en,
    input  logic [1:0]    dim,
    output logic [CW-1:0] pix
);
    logic [CW:0]   sum;
    logic [CW-1:0] mix;

    // floor((prev+cur)/2) in CW+1 bits, then optional dimming
    always_comb begin
        sum = {1'b0, cur} + {1'b0, prev};
        mix = blend_en ? sum[CW:1] : cur;
        case (dim)
            2'd1:    pix = mix >> 1;
            2'd2:    pix = mix >> 2;
            2'd3:    pix = '0;
            default: pix = mix;
        endcase
    end
endmodule

module jtframe_linemult #(
    parameter  int COLORW = 4,
    parameter  int HLEN   = 512,
    parameter  int FACTOR = 2,
    localparam int DW     = 3*COLORW,
    localparam int AW     = (HLEN <= 512) ? 9 : 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          pxlx_cen,
    input  logic [DW-1:0] base_pxl,
    input  logic          HS,
    input  logic          VS,
    input  logic [1:0]    sl_mode,
    input  logic          blend_en,
    output logic [DW-1:0] x_pxl,
    output logic          x_HS,
    output logic          x_VS,
    output logic [1:0]    x_sub
);
    if (FACTOR < 2 || FACTOR > 4) begin : g_factor_check
        $error("jtframe_linemult: FACTOR must be 2, 3 or 4");
    end

    localparam logic [1:0]    LAST = 2'(FACTOR-1);
    localparam logic [AW-1:0] WMAX = '1;

    logic                   line;
    logic                   last_hs;
    logic [AW-1:0]          wraddr, rdaddr, hlen, hswidth;
    logic [DW-1:0]          mem [0:(2**(AW+1))-1];
    logic [DW-1:0]          q;
    logic [2:0][COLORW-1:0] cur, prev, pix;
    logic [1:0]             cur_sub;
    logic [1:0]             dim;
    logic                   pxlx_d;
    logic                   hs_rise, hs_fall;

    assign hs_rise = pxlx_cen &  HS & ~last_hs;
    assign hs_fall = pxlx_cen & ~HS &  last_hs;

    // Write side: bank swap and line length capture on HS, saturating write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line    <= 1'b0;
            last_hs <= 1'b0;
            wraddr  <= '0;
            hlen    <= '0;
            hswidth <= '0;
        end else begin
            if (pxlx_cen) last_hs <= HS;
            if (hs_rise) begin
                line   <= ~line;
                hlen   <= wraddr;
                wraddr <= '0;
            end else if (pxl_cen && wraddr != WMAX) begin
                wraddr <= wraddr + 1'b1;
            end
            if (hs_fall) hswidth <= wraddr;
        end
    end

    // Line buffer: write the filling bank, registered read of the replay bank
    always_ff @(posedge clk) begin
        if (pxl_cen) mem[{~line, wraddr}] <= base_pxl;
        q <= mem[{line, rdaddr}];
    end

    // Read side: replay pointer, sub-line counter and regenerated syncs.
    // An HS rising edge always wins over a pointer wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdaddr <= '0;
            x_sub  <= 2'd0;
            x_HS   <= 1'b0;
            x_VS   <= 1'b0;
        end else if (hs_rise) begin
            rdaddr <= '0;
            x_sub  <= 2'd0;
            x_HS   <= 1'b1;
            x_VS   <= VS;
        end else if (pxlx_cen) begin
            if (rdaddr == hlen) begin
                rdaddr <= '0;
                x_HS   <= 1'b1;
                if (x_sub != LAST) x_sub <= x_sub + 2'd1;
            end else begin
                rdaddr <= rdaddr + 1'b1;
                if (rdaddr == hswidth) x_HS <= 1'b0;
            end
        end
    end

    // Pixel pipeline: cur/prev advance on pxlx_cen; prev is black for the
    // first pixel of a sub-line so blending never mixes in the previous line.
    // cur_sub tags cur with the sub-line it was fetched in, so dimming covers
    // exactly the pixels of the last sub-line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= '0;
            prev    <= '0;
            cur_sub <= 2'd0;
            pxlx_d  <= 1'b0;
            x_pxl   <= '0;
        end else begin
            pxlx_d <= pxlx_cen;
            if (pxlx_cen) begin
                cur     <= q;
                prev    <= (rdaddr == '0) ? '0 : cur;
                cur_sub <= x_sub;
            end
            if (pxlx_d) x_pxl <= pix;
        end
    end

    assign dim = (cur_sub == LAST) ? sl_mode : 2'd0;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        jtframe_linemult_ch #(.CW(COLORW)) u_ch (
            .cur      (cur[i]),
            .prev     (prev[i]),
            .blend_en (blend_en),
            .dim      (dim),
            .pix      (pix[i])
        );
    end
endmodule

// File: tb/tb_jtframe_linemult.sv
// Scoreboard bench for jtframe_linemult with FACTOR=3. The driver pushes the
// expected replay of the previous line when it starts each input line; the
// monitor pops one entry per output pixel.
module tb_jtframe_linemult;
    localparam int COLORW = 4;
    localparam int FACTOR = 3;
    localparam int DW     = 12;
    localparam int HW     = 2;   // HS high for 3 input slots -> hswidth 2
    localparam int NL     = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pxl_cen = 1'b0, pxlx_cen = 1'b0;
    logic [DW-1:0] base_pxl = '0;
    logic          HS = 1'b0, VS = 1'b0;
    logic [1:0]    sl_mode = 2'd0;
    logic          blend_en = 1'b0;
    logic [DW-1:0] x_pxl;
    logic          x_HS, x_VS;
    logic [1:0]    x_sub;

    jtframe_linemult #(.COLORW(COLORW), .HLEN(512), .FACTOR(FACTOR)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxlx_cen(pxlx_cen),
        .base_pxl(base_pxl), .HS(HS), .VS(VS), .sl_mode(sl_mode),
        .blend_en(blend_en), .x_pxl(x_pxl), .x_HS(x_HS), .x_VS(x_VS),
        .x_sub(x_sub)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pxl;
        logic        chk;
        logic        hs;
        logic [1:0]  sub;
        logic        vs;
        int          line;
        int          m;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [11:0] ld [0:NL-1][0:15];
    int          llen [0:NL-1];
    logic        lvs [0:NL-1];
    logic        lbl [0:NL-1];
    logic [1:0]  lsl [0:NL-1];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference pixel: per channel average (when blending) then dimming on the last sub-line
    function automatic logic [11:0] exp_pix(input logic [11:0] c, input logic [11:0] p,
                                            input logic bl, input int s, input logic [1:0] sl);
        logic [11:0] r;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int cv;
            int pv;
            int v;
            cv = int'(c[ch*4 +: 4]);
            pv = int'(p[ch*4 +: 4]);
            v  = bl ? (cv + pv) / 2 : cv;
            if (s == FACTOR-1) begin
                case (sl)
                    2'd1: v = v / 2;
                    2'd2: v = v / 4;
                    2'd3: v = 0;
                    default: ;
                endcase
            end
            r[ch*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    // Expected outputs for every pxlx_cen during input line k (replaying line k-1)
    task automatic push_period(input int k);
        int lp, n, a, s;
        exp_t x;
        logic [11:0] pv;
        lp = llen[k-1];
        n  = FACTOR * llen[k];
        for (int m = 0; m < n; m++) begin
            x.line = k;
            x.m    = m;
            x.vs   = lvs[k];
            x.sub  = 2'((m / lp > FACTOR-1) ? FACTOR-1 : m / lp);
            x.hs   = (m % lp) <= HW;
            if (m == 0) begin
                x.chk = 1'b0;
                x.pxl = '0;
            end else begin
                a = (m - 1) % lp;
                s = (m - 1) / lp;
                if (s > FACTOR-1) s = FACTOR-1;
                pv    = (a == 0) ? 12'h000 : ld[k-1][a-1];
                x.pxl = exp_pix(ld[k-1][a], pv, lbl[k], s, lsl[k]);
                x.chk = 1'b1;
            end
            sb.push_back(x);
        end
    endtask

    // One input pixel slot: 6 clk, pxl_cen once, pxlx_cen every other clk
    task automatic drive_slot(input logic [11:0] p, input logic hs, input logic first,
                              input logic vs, input logic bl, input logic [1:0] sl);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pxl_cen  = (c == 0);
            pxlx_cen = (c % 2 == 0);
            if (c == 0) begin
                base_pxl = p;
                HS       = hs;
                if (first) begin
                    VS       = vs;
                    blend_en = bl;
                    sl_mode  = sl;
                end
            end
        end
    endtask

    // Input line k: slot 0 carries the previous line's last pixel (written as HS rises)
    task automatic drive_line(input int k);
        logic [11:0] p;
        if (k > 0) push_period(k);
        for (int j = 0; j < llen[k]; j++) begin
            if (j == 0) p = (k > 0) ? ld[k-1][llen[k-1]-1] : 12'h000;
            else        p = ld[k][j-1];
            drive_slot(p, j < 3, j == 0, lvs[k], lbl[k], lsl[k]);
        end
    endtask

    // Monitor: one scoreboard entry per output pixel, sampled after x_pxl settles
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && pxlx_cen && sb.size() > 0) begin
                @(posedge clk);
                @(negedge clk);
                e = sb.pop_front();
                n_chk++;
                if (x_HS !== e.hs || x_sub !== e.sub || x_VS !== e.vs ||
                    (e.chk && x_pxl !== e.pxl)) begin
                    n_fail++;
                    $display("FAIL replay line%0d m%0d: got pxl=%h hs=%b sub=%0d vs=%b, want pxl=%h(chk %b) hs=%b sub=%0d vs=%b",
                             e.line, e.m, x_pxl, x_HS, x_sub, x_VS, e.pxl, e.chk, e.hs, e.sub, e.vs);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NL; k++)
            for (int a = 0; a < 16; a++)
                ld[k][a] = 12'((k * 859 + a * 455) & 4095);
        for (int a = 0; a < 16; a++) begin
            ld[0][a] = 12'hF84;
            ld[1][a] = (a == 0) ? 12'h000 : 12'hFFF;
        end
        llen = '{8, 8, 8, 8, 11, 6, 8, 8, 8};
        lvs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lbl  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        lsl  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_state", {x_pxl, x_HS, x_VS, x_sub}, '0);
        rst_n = 1'b1;

        // two F84 lines and part of a third, then reset while outputs are busy
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < ((r == 2) ? 6 : 8); j++)
                drive_slot(12'hF84, j < 3, j == 0, r > 0, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        chk("pre_reset_pxl", x_pxl, 12'hF84);
        chk("pre_reset_hs",  x_HS,  1);
        chk("pre_reset_vs",  x_VS,  1);
        chk("pre_reset_sub", x_sub, 2);
        rst_n = 1'b0;
        #1;
        chk("reset_x_pxl", x_pxl, 0);
        chk("reset_x_hs",  x_HS,  0);
        chk("reset_x_vs",  x_VS,  0);
        chk("reset_x_sub", x_sub, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // main sequence: dimming, blending, VS, longer line, shorter line, blend toggles
        for (int k = 0; k < NL; k++) drive_line(k);

        repeat (10) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
